// File: rtl/pkt_gen.sv
// Per-port descriptor FIFO plus packet expander: each 32-bit descriptor becomes
// one header beat followed by L payload beats on a per-port valid/ready stream.
module pkt_gen #(
   parameter int NPORTS     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [NPORTS-1:0]     desc_en,
   input  logic [31:0]           desc_data,
   output logic [NPORTS-1:0]     pkt_valid,
   output logic [32*NPORTS-1:0]  pkt_data,
   output logic [NPORTS-1:0]     pkt_last,
   input  logic [NPORTS-1:0]     pkt_ready,
   output logic [NPORTS-1:0]     desc_drop,
   output logic [3*NPORTS-1:0]   fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [2:0] FULL = 3'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_PAY  = 2'd2;

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      localparam logic [1:0] PIDX = 2'(p);

      logic [31:0]   mem [FIFO_DEPTH];
      logic [PW-1:0] wr_ptr;
      logic [PW-1:0] rd_ptr;
      logic [2:0]    count;
      logic          drop;
      logic [1:0]    state;
      logic [31:0]   work;
      logic [5:0]    beat;
      logic [5:0]    len;
      logic          pop;
      logic          push_ok;
      logic          pay_last;
      logic [31:0]   lane_data;
      logic          lane_last;

      assign len      = work[29:24];
      assign pop      = (state == S_IDLE) && enable && (count != 3'd0);
      // A full FIFO still accepts a write when the head leaves in the same cycle.
      assign push_ok  = desc_en[p] && ((count != FULL) || pop);
      assign pay_last = (beat == (len - 6'd1));

      always_ff @(posedge clk) begin
         if (push_ok) begin
            mem[wr_ptr] <= desc_data;
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
            drop   <= 1'b0;
         end else begin
            drop <= desc_en[p] && !push_ok;
            if (push_ok) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
               2'b10:   count <= count + 3'd1;
               2'b01:   count <= count - 3'd1;
               default: count <= count;
            endcase
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state <= S_IDLE;
            work  <= '0;
            beat  <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (pop) begin
                     work  <= mem[rd_ptr];
                     beat  <= '0;
                     state <= S_HDR;
                  end
               end
               S_HDR: begin
                  if (pkt_ready[p]) begin
                     state <= (len == 6'd0) ? S_IDLE : S_PAY;
                  end
               end
               S_PAY: begin
                  if (pkt_ready[p]) begin
                     beat <= beat + 6'd1;
                     if (pay_last) begin
                        state <= S_IDLE;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end

      // Beat contents come straight from the working registers, so they hold while stalled.
      always_comb begin
         lane_data = '0;
         lane_last = 1'b0;
         case (state)
            S_HDR: begin
               lane_data = {work[31:24], PIDX, work[21:0]};
               lane_last = (len == 6'd0);
            end
            S_PAY: begin
               lane_data = {2'b00, beat, work[23:0]};
               lane_last = pay_last;
            end
            default: begin
               lane_data = '0;
               lane_last = 1'b0;
            end
         endcase
      end

      assign pkt_valid[p]          = (state != S_IDLE);
      assign pkt_data[32*p +: 32]  = lane_data;
      assign pkt_last[p]           = lane_last;
      assign desc_drop[p]          = drop;
      assign fifo_count[3*p +: 3]  = count;
   end

endmodule

// File: tb/tb_pkt_gen.sv
// Directed bench for pkt_gen: a cycle table for the main flows plus hand-written
// sequences for backpressure, full-with-pop and asynchronous reset.
module tb_pkt_gen;

   logic         clk;
   logic         reset_n;
   logic         enable;
   logic [3:0]   desc_en;
   logic [31:0]  desc_data;
   logic [3:0]   pkt_valid;
   logic [127:0] pkt_data;
   logic [3:0]   pkt_last;
   logic [3:0]   pkt_ready;
   logic [3:0]   desc_drop;
   logic [11:0]  fifo_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0]   en;
      logic [31:0]  din;
      logic         ena;
      logic [3:0]   rdy;
      logic [3:0]   ev;
      logic [127:0] ed;
      logic [3:0]   el;
      logic [11:0]  ec;
      logic [3:0]   edr;
   } vec_t;

   vec_t tbl[$];

   pkt_gen #(.NPORTS(4), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .desc_en    (desc_en),
      .desc_data  (desc_data),
      .pkt_valid  (pkt_valid),
      .pkt_data   (pkt_data),
      .pkt_last   (pkt_last),
      .pkt_ready  (pkt_ready),
      .desc_drop  (desc_drop),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [3:0] en, input logic [31:0] din, input logic ena,
                               input logic [3:0] rdy, input logic [3:0] ev, input logic [127:0] ed,
                               input logic [3:0] el, input logic [11:0] ec, input logic [3:0] edr);
      vec_t v;
      v.en = en; v.din = din; v.ena = ena; v.rdy = rdy;
      v.ev = ev; v.ed = ed; v.el = el; v.ec = ec; v.edr = edr;
      return v;
   endfunction

   // Inputs change just after the rising edge; outputs are read on the falling edge.
   task automatic applyStimulus(input logic [3:0] en, input logic [31:0] din,
                                input logic ena, input logic [3:0] rdy);
      @(posedge clk);
      #1;
      desc_en   = en;
      desc_data = din;
      enable    = ena;
      pkt_ready = rdy;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " valid"}, 128'(pkt_valid), 128'd0);
      checkOutput({tag, " data"},  pkt_data, 128'd0);
      checkOutput({tag, " last"},  128'(pkt_last), 128'd0);
      checkOutput({tag, " drop"},  128'(desc_drop), 128'd0);
      checkOutput({tag, " count"}, 128'(fifo_count), 128'd0);
   endtask

   initial begin
      vec_t v;
      logic [31:0] held_data;
      logic        held_last;
      logic        held;
      int          idx;

      reset_n   = 1'b0;
      enable    = 1'b0;
      desc_en   = 4'b0;
      desc_data = 32'h0;
      pkt_ready = 4'hF;
      #2;
      checkAllZero("reset");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Port 0: L=3 packet
      tbl.push_back(mk(4'b0001, 32'h430000AB, 1, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h001, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0001, {96'h0, 32'h430000AB}, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0001, {96'h0, 32'h000000AB}, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0001, {96'h0, 32'h010000AB}, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0001, {96'h0, 32'h020000AB}, 4'h1, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h000, 4'h0));
      // Port 2: header-only
      tbl.push_back(mk(4'b0100, 32'h000000CD, 1, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h040, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0100, {32'h0, 32'h008000CD, 64'h0}, 4'h4, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h000, 4'h0));
      // Port 3: five writes with enable low, then drain four packets
      tbl.push_back(mk(4'b1000, 32'h01000001, 0, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(4'b1000, 32'h01000002, 0, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h200, 4'h0));
      tbl.push_back(mk(4'b1000, 32'h01000003, 0, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h400, 4'h0));
      tbl.push_back(mk(4'b1000, 32'h01000004, 0, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h600, 4'h0));
      tbl.push_back(mk(4'b1000, 32'h01000005, 0, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h800, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 0, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h800, 4'h8));
      tbl.push_back(mk(4'b0000, 32'h0, 0, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h800, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h800, 4'h0));
      for (int k = 1; k <= 4; k++) begin
         tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b1000, {32'h01C00000 | 32'(k), 96'h0}, 4'h0,
                          12'(4 - k) << 9, 4'h0));
         tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b1000, {32'(k), 96'h0}, 4'h8,
                          12'(4 - k) << 9, 4'h0));
         tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0000, 128'h0, 4'h0, 12'(4 - k) << 9, 4'h0));
      end
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h000, 4'h0));
      // Port 1 stalled while port 0 streams
      tbl.push_back(mk(4'b0010, 32'h42000061, 1, 4'hD, 4'b0000, 128'h0, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0001, 32'h03000071, 1, 4'hD, 4'b0000, 128'h0, 4'h0, 12'h008, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hD, 4'b0010, {64'h0, 32'h42400061, 32'h0}, 4'h0, 12'h001, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hD, 4'b0011, {64'h0, 32'h42400061, 32'h03000071}, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hD, 4'b0011, {64'h0, 32'h42400061, 32'h00000071}, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hD, 4'b0011, {64'h0, 32'h42400061, 32'h01000071}, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hD, 4'b0011, {64'h0, 32'h42400061, 32'h02000071}, 4'h1, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hD, 4'b0010, {64'h0, 32'h42400061, 32'h0}, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0010, {64'h0, 32'h42400061, 32'h0}, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0010, {64'h0, 32'h00000061, 32'h0}, 4'h0, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0010, {64'h0, 32'h01000061, 32'h0}, 4'h2, 12'h000, 4'h0));
      tbl.push_back(mk(4'b0000, 32'h0, 1, 4'hF, 4'b0000, 128'h0, 4'h0, 12'h000, 4'h0));

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         applyStimulus(v.en, v.din, v.ena, v.rdy);
         checkOutput($sformatf("v%0d valid", i), 128'(pkt_valid), 128'(v.ev));
         for (int p = 0; p < 4; p++) begin
            if (v.ev[p]) begin
               checkOutput($sformatf("v%0d data%0d", i, p), 128'(pkt_data[32*p +: 32]), 128'(v.ed[32*p +: 32]));
               checkOutput($sformatf("v%0d last%0d", i, p), 128'(pkt_last[p]), 128'(v.el[p]));
            end
         end
         checkOutput($sformatf("v%0d count", i), 128'(fifo_count), 128'(v.ec));
         checkOutput($sformatf("v%0d drop", i), 128'(desc_drop), 128'(v.edr));
      end

      // Backpressure on port 1: L=5, ready toggles every cycle
      applyStimulus(4'b0010, 32'h05000011, 1, 4'hF);
      idx  = 0;
      held = 1'b0;
      held_data = 32'h0;
      held_last = 1'b0;
      for (int c = 0; c < 40; c++) begin
         applyStimulus(4'b0000, 32'h0, 1, (c % 2 == 1) ? 4'b1111 : 4'b1101);
         if (pkt_valid[1]) begin
            if (held) begin
               checkOutput("bp stable data", 128'(pkt_data[63:32]), 128'(held_data));
               checkOutput("bp stable last", 128'(pkt_last[1]), 128'(held_last));
            end
            if (idx >= 6) begin
               checkOutput("bp extra beat", 128'(idx), 128'd5);
            end else if (pkt_ready[1]) begin
               checkOutput($sformatf("bp beat%0d", idx), 128'(pkt_data[63:32]),
                           (idx == 0) ? 128'h05400011 : 128'(((idx - 1) << 24) | 32'h11));
               checkOutput($sformatf("bp last%0d", idx), 128'(pkt_last[1]), 128'(idx == 5));
               idx++;
               held = 1'b0;
            end else begin
               held      = 1'b1;
               held_data = pkt_data[63:32];
               held_last = pkt_last[1];
            end
         end
      end
      checkOutput("bp beat count", 128'(idx), 128'd6);

      // Full FIFO on port 0 with a write in the same cycle as the pop
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(4'b0001, 32'h00000020 | 32'(k), 0, 4'hF);
      end
      applyStimulus(4'b0001, 32'h00000025, 1, 4'hF);
      checkOutput("fp count full", 128'(fifo_count[2:0]), 128'd4);
      idx = 0;
      for (int c = 0; c < 30; c++) begin
         applyStimulus(4'b0000, 32'h0, 1, 4'hF);
         if (c == 0) begin
            checkOutput("fp no drop", 128'(desc_drop), 128'd0);
            checkOutput("fp count held", 128'(fifo_count[2:0]), 128'd4);
         end
         if (pkt_valid[0]) begin
            checkOutput($sformatf("fp hdr%0d", idx), 128'(pkt_data[31:0]), 128'(32'h21 + 32'(idx)));
            checkOutput($sformatf("fp last%0d", idx), 128'(pkt_last[0]), 128'd1);
            idx++;
         end
      end
      checkOutput("fp packet count", 128'(idx), 128'd5);

      // Asynchronous reset while ports 0 and 1 are mid-packet
      applyStimulus(4'b0001, 32'h0A000031, 1, 4'hF);
      applyStimulus(4'b0010, 32'h4A000041, 1, 4'hF);
      applyStimulus(4'b0001, 32'h0A000032, 1, 4'hF);
      applyStimulus(4'b0001, 32'h0A000033, 1, 4'hF);
      applyStimulus(4'b0000, 32'h0, 1, 4'hF);
      checkOutput("rst pre p0 data", 128'(pkt_data[31:0]), 128'h01000031);
      checkOutput("rst pre p1 data", 128'(pkt_data[63:32]), 128'h00000041);
      checkOutput("rst pre count", 128'(fifo_count), 128'h002);
      #1;
      reset_n = 1'b0;
      #1;
      checkAllZero("rst async");
      applyStimulus(4'b0000, 32'h0, 1, 4'hF);
      applyStimulus(4'b0000, 32'h0, 1, 4'hF);
      #1;
      reset_n = 1'b1;
      applyStimulus(4'b0000, 32'h0, 1, 4'hF);
      checkAllZero("rst after");
      applyStimulus(4'b0000, 32'h0, 1, 4'hF);
      checkAllZero("rst empty");
      applyStimulus(4'b0001, 32'h01000051, 1, 4'hF);
      applyStimulus(4'b0000, 32'h0, 1, 4'hF);
      checkOutput("rst new count", 128'(fifo_count), 128'h001);
      applyStimulus(4'b0000, 32'h0, 1, 4'hF);
      checkOutput("rst new valid", 128'(pkt_valid), 128'h1);
      checkOutput("rst new hdr", 128'(pkt_data[31:0]), 128'h01000051);
      checkOutput("rst new hdr last", 128'(pkt_last[0]), 128'd0);
      applyStimulus(4'b0000, 32'h0, 1, 4'hF);
      checkOutput("rst new pay", 128'(pkt_data[31:0]), 128'h00000051);
      checkOutput("rst new pay last", 128'(pkt_last[0]), 128'd1);
      applyStimulus(4'b0000, 32'h0, 1, 4'hF);
      checkOutput("rst new idle", 128'(pkt_valid), 128'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pkt_gen.md
# pkt_gen

Per-port packet generator that sits directly downstream of the software register interface. It captures the 32-bit descriptor words that software writes for each of the four input ports (`desc_en[i]` / `desc_data`) into a 4-deep descriptor FIFO per port. It expands each descriptor into a header beat plus N payload beats on a valid/ready stream into the ingress stage. Generation is gated by the experiment-enable control.

## Interface
- `NPORTS`, 4: number of input ports; fixed at 4 for this design.
- `FIFO_DEPTH`, 4: descriptor FIFO entries per port; must be a power of two.
- `clk`  in  1: single clock, all state on rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `enable`  in  1: experimenting flag; gates packet starts.
- `desc_en`  in  4: one-cycle write strobe per port; one-hot or zero.
- `desc_data`  in  32: descriptor, sampled when any `desc_en` bit is 1.
- `pkt_valid`  out  4: beat valid per port.
- `pkt_data`  out  128: beat data; port i occupies bits [32i+31:32i].
- `pkt_last`  out  4: final beat of packet, qualified by `pkt_valid`.
- `pkt_ready`  in  4: ingress accepts beat per port.
- `desc_drop`  out  4: one-cycle pulse when a descriptor was dropped because its FIFO was full.
- `fifo_count`  out  12: occupancy per port, 3 bits each at [3i+2:3i], range 0..4.

## Operation
- Descriptor format:
  - [31:30] destination port.
  - [29:24] payload length L, 0..63.
  - [23:0] tag.
- Header beat is `desc_data` with bits [23:22] replaced by the source port index i.
- Payload beat k, for k = 0..L-1: {2'b00, k[5:0], tag[23:0]}.
- L=0 gives a header-only packet; `pkt_last` is asserted on the header.
- FIFO write: accepted when count<4, or when count==4 and the FSM pops that same cycle. Otherwise the descriptor is dropped and `desc_drop[i]` is pulsed on the next cycle.
- Per-port FSM states:
  - IDLE: if `enable` and FIFO non-empty, pop the head into the working registers, clear the beat counter, and go to HDR.
  - HDR: drive the header. On valid&&ready: if L==0, go to IDLE; else go to PAY.
  - PAY: drive payload beat k. On valid&&ready: k++; after beat L-1 is accepted, go to IDLE.
- `enable` deasserting mid-packet does not abort; the packet completes and no new pop occurs until `enable` returns to 1.
- Ports are fully independent; stalls on one port never affect the others.
- Reset (async, `reset_n`=0):
  - FSMs go to IDLE and FIFOs are emptied.
  - `pkt_valid`, `pkt_last`, `desc_drop`, `pkt_data`, and `fifo_count` all read 0 immediately.
  - A packet in flight is discarded with no partial completion.

## Timing
- `desc_en[i]` high at cycle N: entry is visible in `fifo_count` at N+1.
- If the FIFO was empty, the FSM was IDLE, and `enable`=1: pop at N+1, header `pkt_valid` at N+2.
- A beat transfers on valid&&ready. While valid && !ready, `pkt_data` and `pkt_last` hold stable.
- Throughput is one beat per cycle within a packet.
- Exactly one IDLE cycle separates the last beat of one packet from the next header. A packet of length L therefore occupies L+2 cycles minimum.
- `fifo_count` updates the cycle after push/pop. Simultaneous push and pop leave the count unchanged.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Count is kept separately, so full and empty are never ambiguous.

## Test plan
- Single packet, port 0:
  - Stimulus: `enable`=1, `pkt_ready`=1; write `desc_en`=0001, data=0x43_0000AB (dest 1, L=3, tag 0xAB).
  - Required: header 0x4300_00AB at N+2; payload 0x000000AB, 0x010000AB, 0x020000AB; `pkt_last` on the third payload beat.
- Header-only packet:
  - Stimulus: L=0 on port 2.
  - Required: one beat with bits [23:22]=2'b10 and `pkt_last`=1, then IDLE.
- Backpressure:
  - Stimulus: toggle `pkt_ready[1]` every cycle during an L=5 packet.
  - Required: exactly 6 beats in order, and data is stable during every stalled cycle.
- FIFO full and drop:
  - Stimulus: `enable`=0; write 5 descriptors to port 3.
  - Required: `fifo_count[11:9]`=4 and a single `desc_drop[3]` pulse after the 5th write. After raising `enable`, exactly 4 packets are emitted in FIFO order.
- Full with simultaneous pop:
  - Stimulus: FIFO holds 4 entries and the FSM pops in the same cycle as a new write.
  - Required: no drop, count stays 4.
- Reset mid-packet and port independence:
  - Stimulus: assert `reset_n`=0 during PAY on port 0 while port 1 is also active.
  - Required: all outputs read 0 asynchronously. After release, FIFOs are empty and new descriptors work normally.
  - Stimulus: hold port 1 stalled while port 0 streams.
  - Required: port 0 is unaffected.
